// File: rtl/m74_cnt_param.sv
// Parametrised 74HC161-style counter: programmable modulus, up/down,
// synchronous clear/load, cascadable TC, registered WRAP and sticky OVF.
module m74_cnt_param #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 0
) (
  input  logic             CP,
  input  logic             MR,
  input  logic             SR,
  input  logic             PEn,
  input  logic [WIDTH-1:0] Di,
  input  logic             CEP,
  input  logic             CET,
  input  logic             UD,
  input  logic             OVF_CLR,
  output logic [WIDTH-1:0] Qo,
  output logic             TC,
  output logic             WRAP,
  output logic             OVF
);

  // TOP is derived without ever forming M itself, so WIDTH=32 with
  // MODULUS=0 needs no 33-bit intermediate.
  localparam logic [WIDTH-1:0] TOP = (MODULUS == 0) ? '1 : WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             at_top, at_zero, wrap_evt;

  assign at_top  = (q_q >= TOP);
  assign at_zero = (q_q == '0);

  always_comb begin
    q_d      = q_q;
    wrap_evt = 1'b0;
    if (SR) begin
      q_d = '0;
    end else if (!PEn) begin
      q_d = Di;
    end else if (CEP && CET) begin
      if (UD) begin
        if (at_top) begin
          q_d      = '0;
          wrap_evt = 1'b1;
        end else begin
          q_d = q_q + ONE;
        end
      end else begin
        if (at_zero) begin
          q_d      = TOP;
          wrap_evt = 1'b1;
        end else begin
          q_d = q_q - ONE;
        end
      end
    end
  end

  // A wrap on the same edge as OVF_CLR keeps the flag set.
  always_comb begin
    wrap_d = wrap_evt;
    ovf_d  = ovf_q;
    if (wrap_evt) begin
      ovf_d = 1'b1;
    end else if (OVF_CLR) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign Qo   = q_q;
  assign TC   = CET & (UD ? at_top : at_zero);
  assign WRAP = wrap_q;
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_m74_cnt_param.sv
// Self-checking bench for m74_cnt_param: decade instance, binary instance
// and a two-stage cascade, all checked against an integer reference model.
module tb_m74_cnt_param;

  logic clk = 1'b0;
  logic mr;
  always #5 clk = ~clk;

  // Instance A: modulo-10
  logic       a_sr, a_pen, a_cep, a_cet, a_ud, a_oc;
  logic [3:0] a_di, a_q;
  logic       a_tc, a_wrap, a_ovf;
  // Instance B: modulo-16
  logic       b_sr, b_pen, b_cep, b_cet, b_ud, b_oc;
  logic [3:0] b_di, b_q;
  logic       b_tc, b_wrap, b_ovf;
  // Cascade
  logic       c_cep, c_cet;
  logic [3:0] c0_q, c1_q;
  logic       c0_tc, c0_wrap, c0_ovf, c1_tc, c1_wrap, c1_ovf;

  m74_cnt_param #(.WIDTH(4), .MODULUS(10)) u_a (
    .CP(clk), .MR(mr), .SR(a_sr), .PEn(a_pen), .Di(a_di), .CEP(a_cep), .CET(a_cet),
    .UD(a_ud), .OVF_CLR(a_oc), .Qo(a_q), .TC(a_tc), .WRAP(a_wrap), .OVF(a_ovf));

  m74_cnt_param #(.WIDTH(4), .MODULUS(0)) u_b (
    .CP(clk), .MR(mr), .SR(b_sr), .PEn(b_pen), .Di(b_di), .CEP(b_cep), .CET(b_cet),
    .UD(b_ud), .OVF_CLR(b_oc), .Qo(b_q), .TC(b_tc), .WRAP(b_wrap), .OVF(b_ovf));

  m74_cnt_param #(.WIDTH(4), .MODULUS(0)) u_c0 (
    .CP(clk), .MR(mr), .SR(1'b0), .PEn(1'b1), .Di(4'd0), .CEP(c_cep), .CET(c_cet),
    .UD(1'b1), .OVF_CLR(1'b0), .Qo(c0_q), .TC(c0_tc), .WRAP(c0_wrap), .OVF(c0_ovf));

  m74_cnt_param #(.WIDTH(4), .MODULUS(0)) u_c1 (
    .CP(clk), .MR(mr), .SR(1'b0), .PEn(1'b1), .Di(4'd0), .CEP(c_cep), .CET(c0_tc),
    .UD(1'b1), .OVF_CLR(1'b0), .Qo(c1_q), .TC(c1_tc), .WRAP(c1_wrap), .OVF(c1_ovf));

  int vectors = 0;
  int miscompares = 0;

  // Reference state: plain integers
  int ma_q, ma_w, ma_o;
  int mb_q, mb_w, mb_o;
  int cnt, casc_wrap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge of a modulo-m counter described by the operating rules.
  task automatic model_edge(input int m, input int sr, input int pen, input int di,
                            input int cep, input int cet, input int ud, input int oc,
                            inout int q, inout int w, inout int o);
    int wr;
    wr = 0;
    if (sr != 0) q = 0;
    else if (pen == 0) q = di;
    else if (cep != 0 && cet != 0) begin
      if (ud != 0) begin
        if (q + 1 >= m) begin q = 0; wr = 1; end
        else q = q + 1;
      end else begin
        if (q == 0) begin q = m - 1; wr = 1; end
        else q = q - 1;
      end
    end
    w = wr;
    if (wr != 0) o = 1;
    else if (oc != 0) o = 0;
  endtask

  task automatic check_all();
    chk("a_q",    a_q,    ma_q);
    chk("a_wrap", a_wrap, ma_w);
    chk("a_ovf",  a_ovf,  ma_o);
    chk("a_tc",   a_tc,   (a_cet && (a_ud ? ma_q >= 9 : ma_q == 0)) ? 1 : 0);
    chk("b_q",    b_q,    mb_q);
    chk("b_wrap", b_wrap, mb_w);
    chk("b_ovf",  b_ovf,  mb_o);
    chk("b_tc",   b_tc,   (b_cet && (b_ud ? mb_q >= 15 : mb_q == 0)) ? 1 : 0);
    chk("casc_q", {c1_q, c0_q}, cnt);
    chk("c0_tc",  c0_tc,  (c_cet && (cnt % 16 == 15)) ? 1 : 0);
    chk("c1_wrap", c1_wrap, casc_wrap);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(10, a_sr, a_pen, a_di, a_cep, a_cet, a_ud, a_oc, ma_q, ma_w, ma_o);
    model_edge(16, b_sr, b_pen, b_di, b_cep, b_cet, b_ud, b_oc, mb_q, mb_w, mb_o);
    if (c_cep && c_cet) begin
      casc_wrap = (cnt == 255) ? 1 : 0;
      cnt = (cnt + 1) % 256;
    end else begin
      casc_wrap = 0;
    end
    #1;
    check_all();
  endtask

  task automatic model_reset();
    ma_q = 0; ma_w = 0; ma_o = 0;
    mb_q = 0; mb_w = 0; mb_o = 0;
    cnt = 0; casc_wrap = 0;
  endtask

  // Pulse MR between edges; outputs must clear with no clock.
  task automatic do_mr();
    mr = 1'b1;
    #1;
    model_reset();
    check_all();
    #1;
    mr = 1'b0;
  endtask

  task automatic a_set(input logic sr, input logic pen, input logic [3:0] di,
                       input logic cep, input logic cet, input logic ud, input logic oc);
    a_sr = sr; a_pen = pen; a_di = di; a_cep = cep; a_cet = cet; a_ud = ud; a_oc = oc;
  endtask

  initial begin
    mr = 1'b1;
    a_set(1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    b_sr = 1'b0; b_pen = 1'b1; b_di = 4'd0; b_cep = 1'b1; b_cet = 1'b1; b_ud = 1'b1; b_oc = 1'b0;
    c_cep = 1'b0; c_cet = 1'b1;
    model_reset();
    #3;
    check_all();
    mr = 1'b0;

    // Reset mid-count at 9, then count 3
    repeat (9) tick();
    chk("b_at9", b_q, 9);
    do_mr();
    repeat (3) tick();
    chk("b_after_rst", b_q, 3);

    // Decade up from 0
    a_set(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    a_sr = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("dec_seq", a_q, i);
      chk("dec_tc", a_tc, (i == 9) ? 1 : 0);
    end
    tick();
    chk("dec_wrap_q", a_q, 0);
    chk("dec_wrap", a_wrap, 1);
    chk("dec_ovf", a_ovf, 1);
    tick();
    chk("dec_wrap_once", a_wrap, 0);
    chk("dec_ovf_sticky", a_ovf, 1);

    // Down through zero, OVF clear, clear-vs-wrap
    a_set(1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    a_pen = 1'b1;
    tick(); chk("dn_1", a_q, 1);
    tick(); chk("dn_0", a_q, 0); chk("dn_tc0", a_tc, 1);
    tick(); chk("dn_9", a_q, 9); chk("dn_wrap", a_wrap, 1);
    a_oc = 1'b1;
    tick(); chk("ovf_clr", a_ovf, 0);
    a_set(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    a_pen = 1'b1; a_oc = 1'b1;
    tick(); chk("clr_vs_wrap", a_ovf, 1);
    a_oc = 1'b0;

    // Priority: SR > load > count; CET gates count and TC
    a_set(1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(); chk("sr_wins", a_q, 0);
    a_sr = 1'b0;
    tick(); chk("load_wins", a_q, 5); chk("load_nowrap", a_wrap, 0);
    a_di = 4'd9;
    tick();
    a_set(1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); chk("cet_hold", a_q, 9); chk("cet_tc", a_tc, 0);

    // Out-of-range loads
    a_set(1'b0, 1'b0, 4'd13, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("oor_load", a_q, 13); chk("oor_tc_up", a_tc, 1);
    a_pen = 1'b1;
    tick(); chk("oor_up_wrap_q", a_q, 0); chk("oor_up_wrap", a_wrap, 1);
    a_set(1'b0, 1'b0, 4'd13, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    a_pen = 1'b1;
    for (int i = 12; i >= 9; i--) begin
      tick();
      chk("oor_dn", a_q, i);
      chk("oor_dn_tc", a_tc, 0);
    end

    // Randomised traffic on A and B
    for (int i = 0; i < 300; i++) begin
      a_set($urandom_range(0, 15) == 0, $urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0);
      b_sr  = ($urandom_range(0, 15) == 0);
      b_pen = ($urandom_range(0, 7) != 0);
      b_di  = 4'($urandom_range(0, 15));
      b_cep = ($urandom_range(0, 3) != 0);
      b_cet = ($urandom_range(0, 3) != 0);
      b_ud  = ($urandom_range(0, 1) == 1);
      b_oc  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) do_mr();
      tick();
    end

    // Cascade: 256 counts from zero
    do_mr();
    c_cep = 1'b1; c_cet = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick();
      chk("casc_seq", {c1_q, c0_q}, i % 256);
    end
    chk("casc_upper_wrap", c1_wrap, 1);
    c_cep = 1'b0;
    tick();
    chk("casc_hold", {c1_q, c0_q}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
